// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_CMP   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_PASSA = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  // Compare and reserved ops leave the accumulator untouched.
  function automatic logic op_writes_acc(op_e op);
    return !(op == OP_CMP || op == OP_RSVD);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result bus between the operand sequencer and alu_pipe.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic             use_acc;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             equal;
  logic             greater;
  logic             lesser;
  logic             zero;
  logic             illegal;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, use_acc, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, result, equal, greater, lesser, zero, illegal, acc
  );

  modport slave (
    input  in_valid, op, use_acc, acc_clr, a, b, out_ready,
    output in_ready, out_valid, result, equal, greater, lesser, zero, illegal, acc
  );

endinterface

// File: rtl/alu_core.sv
// Combinational datapath: one op on the effective operands, plus flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a_eff,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result_c,
  output logic             equal_c,
  output logic             greater_c,
  output logic             lesser_c,
  output logic             zero_c,
  output logic             illegal_c
);

  always_comb begin
    result_c  = '0;
    illegal_c = 1'b0;
    case (op)
      OP_ADD:   result_c = {1'b0, a_eff} + {1'b0, b};
      // msb is the no-borrow bit: set iff a_eff >= b
      OP_SUB:   result_c = {1'b0, a_eff} + {1'b0, ~b} + (WIDTH+1)'(1);
      OP_CMP:   result_c = '0;
      OP_AND:   result_c = {1'b0, a_eff & b};
      OP_OR:    result_c = {1'b0, a_eff | b};
      OP_XOR:   result_c = {1'b0, a_eff ^ b};
      OP_PASSA: result_c = {1'b0, a_eff};
      default: begin
        result_c  = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

  assign equal_c   = (a_eff == b);
  assign greater_c = (a_eff >  b);
  assign lesser_c  = (a_eff <  b);
  assign zero_c    = (result_c[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with an optional accumulator that can stand in for operand A.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  logic             s1_v;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_use_acc;

  logic             out_valid_q;
  logic [WIDTH:0]   result_q;
  logic             equal_q, greater_q, lesser_q, zero_q, illegal_q;
  logic [WIDTH-1:0] acc_q;

  logic             s1_adv_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [WIDTH-1:0] a_eff_c;
  logic [WIDTH:0]   result_c;
  logic             equal_c, greater_c, lesser_c, zero_c, illegal_c;

  assign s1_adv_c   = s1_v && (!out_valid_q || bus.out_ready);
  assign in_ready_c = !s1_v || s1_adv_c;
  assign accept_c   = bus.in_valid && in_ready_c;

  // Accumulator is read at transfer time, so chained ops need no forwarding.
  assign a_eff_c = (ACC_EN && s1_use_acc) ? acc_q : s1_a;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op        (s1_op),
    .a_eff     (a_eff_c),
    .b         (s1_b),
    .result_c  (result_c),
    .equal_c   (equal_c),
    .greater_c (greater_c),
    .lesser_c  (lesser_c),
    .zero_c    (zero_c),
    .illegal_c (illegal_c)
  );

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_op      <= OP_ADD;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_use_acc <= 1'b0;
    end else if (accept_c) begin
      s1_v       <= 1'b1;
      s1_op      <= op_e'(bus.op);
      s1_a       <= bus.a;
      s1_b       <= bus.b;
      s1_use_acc <= bus.use_acc;
    end else if (s1_adv_c) begin
      s1_v <= 1'b0;
    end
  end

  // Stage 2: result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      lesser_q    <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (s1_adv_c) begin
      out_valid_q <= 1'b1;
      result_q    <= result_c;
      equal_q     <= equal_c;
      greater_q   <= greater_c;
      lesser_q    <= lesser_c;
      zero_q      <= zero_c;
      illegal_q   <= illegal_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Accumulator: clear takes priority over a same-cycle update
  always_ff @(posedge clk) begin
    if (rst || !ACC_EN) begin
      acc_q <= '0;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
    end else if (s1_adv_c && op_writes_acc(s1_op)) begin
      acc_q <= result_c[WIDTH-1:0];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.equal     = equal_q;
  assign bus.greater   = greater_q;
  assign bus.lesser    = lesser_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed plus random stimulus for alu_pipe, scored against an in-order ISA-level model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W   = 4;
  localparam int          MOD = 1 << W;

  typedef struct {
    int res;
    bit eq, gt, lt, zr, il;
  } exp_t;

  logic clk;
  logic rst;
  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .ACC_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  exp_t q[$];
  int   model_acc = 0;
  bit   last_accept;
  bit   held_v = 0;
  logic [W:0] held_res;
  logic [4:0] held_flags;

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === 32'(expv)) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Sequential semantics of one op: what the datapath must eventually report.
  function automatic exp_t ref_op(input int o, input int ae, input int bv);
    exp_t e;
    e.eq = (ae == bv);
    e.gt = (ae > bv);
    e.lt = (ae < bv);
    e.il = (o == 7);
    case (o)
      0:       e.res = ae + bv;
      1:       e.res = ((ae >= bv) ? MOD : 0) + ((ae - bv + MOD) % MOD);
      3:       e.res = ae & bv;
      4:       e.res = ae | bv;
      5:       e.res = ae ^ bv;
      6:       e.res = ae;
      default: e.res = 0;
    endcase
    e.zr = ((e.res % MOD) == 0);
    return e;
  endfunction

  task automatic step(input bit vld, input logic [2:0] o, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input bit ua, input bit clr, input bit ordy);
    exp_t e;
    bit   out_fire;
    bus.in_valid  = vld;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.use_acc   = ua;
    bus.acc_clr   = clr;
    bus.out_ready = ordy;
    #1;
    last_accept = vld && bus.in_ready;
    out_fire    = bus.out_valid && ordy;
    if (held_v) begin
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_result", 32'(bus.result), int'(held_res));
      check("stall_flags", 32'({bus.equal, bus.greater, bus.lesser, bus.zero, bus.illegal}),
            int'(held_flags));
    end
    if (out_fire) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(out_fire), 0);
      end else begin
        e = q.pop_front();
        check("result", 32'(bus.result), e.res);
        check("flags", 32'({bus.equal, bus.greater, bus.lesser, bus.zero, bus.illegal}),
              int'({e.eq, e.gt, e.lt, e.zr, e.il}));
      end
    end
    held_v     = bus.out_valid && !ordy;
    held_res   = bus.result;
    held_flags = {bus.equal, bus.greater, bus.lesser, bus.zero, bus.illegal};
    if (last_accept) begin
      e = ref_op(int'(o), ua ? model_acc : int'(av), int'(bv));
      q.push_back(e);
      if (o != 3'd2 && o != 3'd7) model_acc = e.res % MOD;
    end
    if (clr) model_acc = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || bus.out_valid); i++) idle(1'b1);
    check("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.use_acc = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_flags", 32'({bus.equal, bus.greater, bus.lesser, bus.zero, bus.illegal}), 0);
    check("rst_acc", 32'(bus.acc), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);

    // ADD with carry out
    step(1'b1, 3'd0, 4'd9, 4'd8, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("add_valid", 32'(bus.out_valid), 1);
    check("add_result", 32'(bus.result), 17);
    check("add_greater", 32'(bus.greater), 1);
    check("add_zero", 32'(bus.zero), 0);
    check("add_acc", 32'(bus.acc), 1);

    // SUB with and without borrow
    step(1'b1, 3'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
    check("sub_borrow_result", 32'(bus.result), 14);
    check("sub_borrow_lesser", 32'(bus.lesser), 1);
    idle(1'b1);
    check("sub_eq_result", 32'(bus.result), 16);
    check("sub_eq_flags", 32'({bus.equal, bus.zero}), 3);
    drain();

    // Chained accumulate, then compare against the accumulator
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("clr_acc", 32'(bus.acc), 0);
    repeat (4) step(1'b1, 3'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1);
    drain();
    check("accum_acc", 32'(bus.acc), 12);
    step(1'b1, 3'd2, 4'd0, 4'd12, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("cmp_result", 32'(bus.result), 0);
    check("cmp_equal_zero", 32'({bus.equal, bus.zero}), 3);
    drain();
    check("cmp_acc_kept", 32'(bus.acc), 12);

    // Backpressure: two accepted, then stall
    acc_cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 3'd0, 4'(i), 4'(i), 1'b0, 1'b0, 1'b0);
      acc_cnt += int'(last_accept);
    end
    check("bp_accepted", 32'(acc_cnt), 2);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    repeat (2) step(1'b1, 3'd0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
    check("bp_resume_accept", 32'(last_accept), 1);
    drain();
    check("bp_acc", 32'(bus.acc), 6);

    // Reserved opcode
    step(1'b1, 3'd7, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("rsvd_illegal", 32'(bus.illegal), 1);
    check("rsvd_result", 32'(bus.result), 0);
    check("rsvd_zero", 32'(bus.zero), 1);
    drain();
    check("rsvd_acc_kept", 32'(bus.acc), 6);

    // Clear concurrent with an accumulator-updating transfer
    step(1'b1, 3'd0, 4'd4, 4'd4, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("clr_wins_acc", 32'(bus.acc), 0);
    drain();

    // Reset with both stages full
    step(1'b1, 3'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    q.delete();
    model_acc = 0;
    held_v = 0;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_acc", 32'(bus.acc), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("midrst_no_stale", 32'(bus.out_valid), 0);
    end

    // Random traffic; clears only while the pipeline is empty
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom),
           4'($urandom), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 9) < 7);
      if (i % 60 == 59) begin
        drain();
        check("rand_acc", 32'(bus.acc), model_acc);
        step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("rand_clr_acc", 32'(bus.acc), 0);
      end
    end
    drain();
    check("final_acc", 32'(bus.acc), model_acc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
